// File: rtl/dsm_sequencer_pkg.sv
// Shared types and constants for the delta-sigma modulator sequencer.
package dsm_sequencer_pkg;

  localparam int T_BITS_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_RUN     = 2'd2,
    ST_RECOVER = 2'd3
  } dsm_state_e;

  // Modulator output codes; 2'b10 is never driven but counts as non-zero.
  localparam logic [1:0] PWM_ZERO = 2'b00;
  localparam logic [1:0] PWM_POS  = 2'b01;
  localparam logic [1:0] PWM_NEG  = 2'b11;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1 (right-shifting).
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    lfsr_step = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/dsm_sequencer_if.sv
// Input sample stream (valid/ready) feeding the sequencer.
interface dsm_sequencer_if
  import dsm_sequencer_pkg::*;
#(
  parameter int T_BITS = T_BITS_DEF
);
  logic              s_valid;
  logic              s_ready;
  logic [T_BITS-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/dsm_dither_lfsr.sv
// Dither source: 16-bit Galois LFSR, top DITH_BITS taken as a signed
// magnitude and sign-extended to the modulator dither width.
// out reflects the LFSR value the register will hold after this clock, so a
// registered copy of out lines up with the LFSR state of the following cycle.
module dsm_dither_lfsr
  import dsm_sequencer_pkg::*;
#(
  parameter int          T_BITS    = T_BITS_DEF,
  parameter int          DITH_BITS = 4,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              advance,
  input  logic              dith_en,
  output logic [T_BITS-6:0] out
);

  localparam int DW = T_BITS - 5;

  logic [15:0]                 lfsr_q;
  logic [15:0]                 lfsr_d;
  logic signed [DITH_BITS-1:0] mag;

  assign lfsr_d = advance ? lfsr_step(lfsr_q) : lfsr_q;
  assign mag    = lfsr_d[15 -: DITH_BITS];
  assign out    = dith_en ? DW'(mag) : '0;

  // LFSR state; only reset reloads the seed, otherwise it holds when idle.
  always_ff @(posedge clock) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/dsm_sequencer.sv
// Sequencer in front of the delta-sigma modulator: holds input samples for
// OSR clocks, drives dither, and sequences modulator reset for start-up flush
// and overload recovery.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | disabled, modulator held in reset
//   ST_FLUSH   | start-up, modulator reset held RST_CYCLES clocks
//   ST_RUN     | streaming samples, overload monitor and dither active
//   ST_RECOVER | after overload trip, modulator reset held RST_CYCLES clocks
module dsm_sequencer
  import dsm_sequencer_pkg::*;
#(
  parameter int          T_BITS     = T_BITS_DEF,
  parameter int          OSR        = 8,
  parameter int          RST_CYCLES = 4,
  parameter int          OVL_LIMIT  = 32,
  parameter int          DITH_BITS  = 4,
  parameter logic [15:0] LFSR_SEED  = LFSR_SEED_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic              dith_en,
  dsm_sequencer_if.slave    s,
  input  logic [1:0]        pwm,
  output logic [T_BITS-1:0] dsm_vin,
  output logic [T_BITS-6:0] dsm_dith,
  output logic              dsm_reset,
  output logic              ovl_event,
  output logic              underrun,
  output logic [7:0]        ovl_count
);

  localparam int OSR_W = $clog2(OSR);
  localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int OC_W  = $clog2(OVL_LIMIT);
  localparam int DW    = T_BITS - 5;

  dsm_state_e        state_q, state_d;
  logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [OSR_W-1:0]  osr_cnt_q, osr_cnt_d;
  logic [OC_W-1:0]   ovl_cnt_q, ovl_cnt_d;
  logic [1:0]        prev_pwm_q, prev_pwm_d;
  logic [7:0]        ovl_count_q, ovl_count_d;
  logic [T_BITS-1:0] dsm_vin_q, dsm_vin_d;
  logic [DW-1:0]     dsm_dith_q, dsm_dith_d;
  logic              dsm_reset_q, dsm_reset_d;
  logic              ovl_event_q;
  logic              underrun_q, underrun_d;

  logic          in_run;
  logic          slot;
  logic          pwm_nz;
  logic          pwm_same;
  logic          ovl_trip;
  logic          s_ready_c;
  logic          accept;
  logic [DW-1:0] dith_word;

  assign in_run    = (state_q == ST_RUN);
  assign slot      = in_run && (osr_cnt_q == OSR_W'(OSR - 1));
  assign pwm_nz    = (pwm != PWM_ZERO);
  assign pwm_same  = (pwm == prev_pwm_q);
  assign ovl_trip  = in_run && pwm_nz && pwm_same && (ovl_cnt_q == OC_W'(OVL_LIMIT - 1));
  // A tripping clock never offers ready, so a sample is not swallowed by recovery.
  assign s_ready_c = slot && !ovl_trip;
  assign accept    = s_ready_c && s.s_valid;
  assign s.s_ready = s_ready_c;

  dsm_dither_lfsr #(
    .T_BITS    (T_BITS),
    .DITH_BITS (DITH_BITS),
    .LFSR_SEED (LFSR_SEED)
  ) u_dither (
    .clock   (clock),
    .reset   (reset),
    .advance (in_run),
    .dith_en (dith_en),
    .out     (dith_word)
  );

  // Next-state logic for the FSM, the OSR slot counter and the overload monitor.
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    osr_cnt_d   = osr_cnt_q;
    ovl_cnt_d   = ovl_cnt_q;
    prev_pwm_d  = prev_pwm_q;
    ovl_count_d = ovl_count_q;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d   = ST_FLUSH;
          rst_cnt_d = '0;
        end
      end
      ST_FLUSH, ST_RECOVER: begin
        if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) begin
          state_d    = ST_RUN;
          osr_cnt_d  = OSR_W'(OSR - 1);
          prev_pwm_d = PWM_ZERO;
          ovl_cnt_d  = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        osr_cnt_d  = slot ? '0 : osr_cnt_q + 1'b1;
        prev_pwm_d = pwm;
        if (!pwm_nz)       ovl_cnt_d = '0;
        else if (pwm_same) ovl_cnt_d = ovl_cnt_q + 1'b1;
        else               ovl_cnt_d = OC_W'(1);
        if (ovl_trip) begin
          state_d   = ST_RECOVER;
          rst_cnt_d = '0;
          if (ovl_count_q != 8'hFF) ovl_count_d = ovl_count_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!en) state_d = ST_IDLE;
  end

  // Registered modulator-facing outputs follow the state being entered.
  always_comb begin
    dsm_reset_d = (state_d != ST_RUN);
    underrun_d  = s_ready_c && !s.s_valid;
    dsm_dith_d  = (state_d == ST_RUN) ? dith_word : '0;
    if (state_d != ST_RUN) dsm_vin_d = '0;
    else if (accept)       dsm_vin_d = s.s_data;
    else                   dsm_vin_d = dsm_vin_q;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rst_cnt_q   <= '0;
      osr_cnt_q   <= '0;
      ovl_cnt_q   <= '0;
      prev_pwm_q  <= PWM_ZERO;
      ovl_count_q <= '0;
      dsm_vin_q   <= '0;
      dsm_dith_q  <= '0;
      dsm_reset_q <= 1'b1;
      ovl_event_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      osr_cnt_q   <= osr_cnt_d;
      ovl_cnt_q   <= ovl_cnt_d;
      prev_pwm_q  <= prev_pwm_d;
      ovl_count_q <= ovl_count_d;
      dsm_vin_q   <= dsm_vin_d;
      dsm_dith_q  <= dsm_dith_d;
      dsm_reset_q <= dsm_reset_d;
      ovl_event_q <= ovl_trip;
      underrun_q  <= underrun_d;
    end
  end

  assign dsm_vin   = dsm_vin_q;
  assign dsm_dith  = dsm_dith_q;
  assign dsm_reset = dsm_reset_q;
  assign ovl_event = ovl_event_q;
  assign underrun  = underrun_q;
  assign ovl_count = ovl_count_q;

endmodule

// File: tb/tb_dsm_sequencer.sv
// Directed bench for dsm_sequencer with default parameters
// (T_BITS=15, OSR=8, RST_CYCLES=4, OVL_LIMIT=32, DITH_BITS=4, seed ACE1).
module tb_dsm_sequencer;
  import dsm_sequencer_pkg::*;

  logic        clock;
  logic        reset;
  logic        en;
  logic        dith_en;
  logic [1:0]  pwm;
  logic [14:0] dsm_vin;
  logic [9:0]  dsm_dith;
  logic        dsm_reset;
  logic        ovl_event;
  logic        underrun;
  logic [7:0]  ovl_count;

  int          n_chk;
  int          n_bad;
  logic [15:0] lfsr_m;

  dsm_sequencer_if #(.T_BITS(15)) s_if ();

  dsm_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .en        (en),
    .dith_en   (dith_en),
    .s         (s_if),
    .pwm       (pwm),
    .dsm_vin   (dsm_vin),
    .dsm_dith  (dsm_dith),
    .dsm_reset (dsm_reset),
    .ovl_event (ovl_event),
    .underrun  (underrun),
    .ovl_count (ovl_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] dith_of(input logic [15:0] l);
    return {{6{l[15]}}, l[15:12]};
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    logic [15:0] n;
    n = l >> 1;
    if (l[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  // One clock; sample 1 ns after the edge and check dither against the model.
  task automatic step();
    logic de;
    de = dith_en;
    @(posedge clock);
    #1;
    if (dsm_reset == 1'b0) begin
      chk("dith_run", dsm_dith, de ? dith_of(lfsr_m) : 10'h000);
      lfsr_m = lfsr_next(lfsr_m);
    end else begin
      chk("dith_off", dsm_dith, 10'h000);
    end
  endtask

  task automatic startup();
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("flush_rst", dsm_reset, 1'b1);
      chk("flush_rdy", s_if.s_ready, 1'b0);
    end
    step();
    chk("run_rst", dsm_reset, 1'b0);
    chk("run_rdy", s_if.s_ready, 1'b1);
  endtask

  // Called at a slot clock; covers the accept edge and the next 7 clocks.
  task automatic do_slot(input logic v, input logic [14:0] d, input logic [14:0] exp_vin);
    s_if.s_valid = v;
    s_if.s_data  = d;
    chk("slot_rdy", s_if.s_ready, 1'b1);
    step();
    chk("slot_vin", dsm_vin, exp_vin);
    chk("slot_unr", underrun, !v);
    s_if.s_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("hold_rdy", s_if.s_ready, (i == 6));
      chk("hold_vin", dsm_vin, exp_vin);
      chk("hold_unr", underrun, 1'b0);
    end
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    lfsr_m = 16'hACE1;
    reset = 1'b1;
    en = 1'b0;
    dith_en = 1'b1;
    pwm = PWM_ZERO;
    s_if.s_valid = 1'b0;
    s_if.s_data = '0;

    step();
    step();
    chk("rst_dsm_reset", dsm_reset, 1'b1);
    chk("rst_vin", dsm_vin, 15'h0);
    chk("rst_rdy", s_if.s_ready, 1'b0);
    chk("rst_ovl_event", ovl_event, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
    chk("rst_ovl_count", ovl_count, 8'd0);

    reset = 1'b0;
    step();
    chk("idle_rst", dsm_reset, 1'b1);
    chk("idle_rdy", s_if.s_ready, 1'b0);

    startup();
    chk("dith_first", dsm_dith, 10'h3FA);

    do_slot(1'b1, 15'h0100, 15'h0100);
    do_slot(1'b1, 15'h0200, 15'h0200);
    do_slot(1'b0, 15'h1234, 15'h0200);
    do_slot(1'b1, 15'h7F00, 15'h7F00);

    // 31 identical codes then zero: no trip.
    s_if.s_valid = 1'b1;
    s_if.s_data = 15'h0300;
    pwm = PWM_POS;
    for (int i = 0; i < 31; i++) begin
      step();
      chk("neg_evt", ovl_event, 1'b0);
    end
    pwm = PWM_ZERO;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("neg_evt0", ovl_event, 1'b0);
      chk("neg_rst", dsm_reset, 1'b0);
    end

    // 32 identical codes: trip, recover, resume.
    pwm = PWM_POS;
    for (int i = 0; i < 31; i++) begin
      step();
      chk("pre_trip_evt", ovl_event, 1'b0);
      chk("pre_trip_rst", dsm_reset, 1'b0);
    end
    step();
    chk("trip_evt", ovl_event, 1'b1);
    chk("trip_rst", dsm_reset, 1'b1);
    chk("trip_vin", dsm_vin, 15'h0);
    chk("trip_cnt", ovl_count, 8'd1);
    pwm = PWM_ZERO;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rec_evt", ovl_event, 1'b0);
      chk("rec_rst", dsm_reset, 1'b1);
      chk("rec_rdy", s_if.s_ready, 1'b0);
    end
    step();
    chk("resume_rst", dsm_reset, 1'b0);
    chk("resume_cnt", ovl_count, 8'd1);
    do_slot(1'b1, 15'h0400, 15'h0400);

    // Dither disabled then re-enabled.
    s_if.s_valid = 1'b1;
    s_if.s_data = 15'h0450;
    dith_en = 1'b0;
    for (int i = 0; i < 5; i++) step();
    dith_en = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Second trip with negative code, then abort during recovery.
    pwm = PWM_NEG;
    for (int i = 0; i < 32; i++) step();
    chk("trip2_evt", ovl_event, 1'b1);
    chk("trip2_cnt", ovl_count, 8'd2);
    pwm = PWM_ZERO;
    step();
    en = 1'b0;
    step();
    chk("abort_rst", dsm_reset, 1'b1);
    chk("abort_rdy", s_if.s_ready, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort_hold_rst", dsm_reset, 1'b1);
      chk("abort_hold_rdy", s_if.s_ready, 1'b0);
    end
    startup();
    chk("restart_vin", dsm_vin, 15'h0);
    chk("restart_cnt", ovl_count, 8'd2);
    do_slot(1'b1, 15'h0500, 15'h0500);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
